// File: rtl/alu_op_sequencer.sv
// Board-level ALU sequencer: latches operand A and an opcode on a rising Go, runs
// the operation against the low half of the accumulator and pulses Done on write-back.
module alu_op_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic               CLOCK_50,
  input  logic               Reset,
  input  logic [WIDTH-1:0]   Data,
  input  logic [2:0]         Function,
  input  logic               Go,
  output logic [2*WIDTH-1:0] Result,
  output logic               Busy,
  output logic               Done,
  output logic               OpErr,
  output logic [1:0]         dbg_state
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

  // Handshake: Go is a level; an op starts only on its rising edge while idle.
  // Busy covers the cycle after start through the Done cycle inclusive.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      step_q, step_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         f_q, f_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               operr_q, operr_d;
  logic               go_q, go_d;

  logic               go_rise;
  logic [2*WIDTH-1:0] a_ext, b_ext, addend;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    a_d      = a_q;
    b_d      = b_q;
    f_d      = f_q;
    p_d      = p_q;
    result_d = result_q;
    operr_d  = operr_q;
    done_d   = 1'b0;
    go_d     = Go;
    go_rise  = Go & ~go_q;
    a_ext    = {{WIDTH{1'b0}}, a_q};
    b_ext    = {{WIDTH{1'b0}}, b_q};
    addend   = b_q[step_q] ? (a_ext << step_q) : '0;

    case (state_q)
      S_IDLE: begin
        if (go_rise) begin
          a_d     = Data;
          f_d     = Function;
          b_d     = result_q[WIDTH-1:0];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        operr_d = 1'b0;
        case (f_q)
          3'd0: result_d = a_ext + b_ext;
          3'd1: result_d = a_ext - b_ext;
          3'd2: begin
            p_d     = '0;
            step_d  = '0;
            state_d = S_MUL;
            done_d  = 1'b0;
            operr_d = operr_q;
          end
          3'd3: result_d = {a_q, b_q};
          3'd4: result_d = {a_q ^ b_q, a_q | b_q};
          3'd7: result_d = '0;
          default: operr_d = 1'b1;
        endcase
      end
      S_MUL: begin
        // The last partial product goes straight to Result so P never shows.
        if (step_q == LAST_STEP) begin
          result_d = p_q + addend;
          done_d   = 1'b1;
          operr_d  = 1'b0;
          state_d  = S_IDLE;
        end else begin
          p_d    = p_q + addend;
          step_d = step_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) | done_d;
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      f_q      <= '0;
      p_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      operr_q  <= 1'b0;
      go_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      a_q      <= a_d;
      b_q      <= b_d;
      f_q      <= f_d;
      p_q      <= p_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      operr_q  <= operr_d;
      go_q     <= go_d;
    end
  end

  assign Result    = result_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign OpErr     = operr_q;
  assign dbg_state = state_q;

endmodule
